bram_port_arbiter: RTL and testbench

Two-requester arbiter for BRAM port B (data port) of the 5-stage core. It shares the port between the pipeline MEM stage (CPU) and the program loader (LDR), which writes program images into BRAM or reads them back. CPU has priority outside loader bursts, and the CPU is stalled while the loader owns the port. The block also tracks the 1-cycle BRAM read latency and returns read data only to the requester that issued the read.

---
 rtl/bram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter (CPU MEM stage / program loader) for BRAM port B.
// Build option: BRAM_ARB_LDR_READ_EN enables loader reads (default: write-only loader).
module bram_port_arbiter #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_rvalid,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_e;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    owner_e      owner_q, owner_d;
    owner_e      tag_q, tag_d;
    logic [7:0]  beat_q, beat_d;
    logic [15:0] stall_q, stall_d;

    logic ldr_req_eff;
    logic gnt_cpu;
    logic gnt_ldr;

`ifdef BRAM_ARB_LDR_READ_EN
    assign ldr_req_eff = ldr_req;
    assign ldr_rdata   = bram_rdata;
`else
    // Loader reads are invisible to arbitration in the write-only build.
    assign ldr_req_eff = ldr_req & ldr_we;
    assign ldr_rdata   = '0;
`endif

    // Grants are suppressed while reset is held so outputs reflect the reset state.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_ldr = 1'b0;
        if (!rst) begin
            if (owner_q == OWN_LDR && ldr_req_eff && beat_q < MAX_B) begin
                gnt_ldr = 1'b1;
            end else if (cpu_req) begin
                gnt_cpu = 1'b1;
            end else if (ldr_req_eff) begin
                gnt_ldr = 1'b1;
            end
        end
    end

    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 4'h0;
        bram_addr  = '0;
        bram_wdata = '0;
        if (gnt_cpu) begin
            bram_en    = 1'b1;
            bram_we    = {4{cpu_we}};
            bram_addr  = cpu_addr;
            bram_wdata = cpu_wdata;
        end else if (gnt_ldr) begin
            bram_en    = 1'b1;
            bram_we    = {4{ldr_we}};
            bram_addr  = ldr_addr;
            bram_wdata = ldr_wdata;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        tag_d   = OWN_NONE;
        beat_d  = 8'd0;
        stall_d = stall_q;
        if (gnt_cpu) begin
            owner_d = OWN_CPU;
            if (!cpu_we) tag_d = OWN_CPU;
        end else if (gnt_ldr) begin
            owner_d = OWN_LDR;
            if (!ldr_we) tag_d = OWN_LDR;
            beat_d = (owner_q == OWN_LDR) ? beat_q + 8'd1 : 8'd1;
        end
        if (cpu_stall && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            tag_q   <= OWN_NONE;
            beat_q  <= 8'd0;
            stall_q <= 16'd0;
        end else begin
            owner_q <= owner_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
        end
    end

    assign cpu_stall = cpu_req & ~gnt_cpu;
    assign ldr_gnt   = gnt_ldr;
    assign stall_cnt = stall_q;
    assign cpu_rdata = bram_rdata;

    // A read in flight when reset arrives must not report valid data.
    assign cpu_rvalid = (tag_q == OWN_CPU) & ~rst;
`ifdef BRAM_ARB_LDR_READ_EN
    assign ldr_rvalid = (tag_q == OWN_LDR) & ~rst;
`else
    assign ldr_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter.
// Instance A (MAX_BURST=8) covers function; instance B (MAX_BURST=255) covers stall_cnt saturation.
`timescale 1ns/1ps
module tb_bram_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [10:0] cpu_addr, ldr_addr;
    logic [31:0] cpu_wdata, ldr_wdata;
    logic        cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid, bram_en;
    logic [31:0] cpu_rdata, ldr_rdata, bram_wdata, bram_rdata;
    logic [3:0]  bram_we;
    logic [10:0] bram_addr;
    logic [15:0] stall_cnt;

    logic [31:0] mem [0:2047];

    bram_port_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_BURST(8)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt),
        .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .stall_cnt(stall_cnt)
    );

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we != 4'h0) mem[bram_addr] <= bram_wdata;
            bram_rdata <= mem[bram_addr];
        end
    end

    logic        b_cpu_req, b_ldr_req;
    logic        b_cpu_stall, b_cpu_rvalid, b_ldr_gnt, b_ldr_rvalid, b_bram_en;
    logic [31:0] b_cpu_rdata, b_ldr_rdata, b_bram_wdata;
    logic [3:0]  b_bram_we;
    logic [10:0] b_bram_addr;
    logic [15:0] b_stall_cnt;

    bram_port_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_BURST(255)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(b_cpu_req), .cpu_we(1'b1), .cpu_addr(11'h7F0),
        .cpu_wdata(32'h0), .cpu_stall(b_cpu_stall),
        .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
        .ldr_req(b_ldr_req), .ldr_we(1'b1), .ldr_addr(11'h001),
        .ldr_wdata(32'h0), .ldr_gnt(b_ldr_gnt),
        .ldr_rdata(b_ldr_rdata), .ldr_rvalid(b_ldr_rvalid),
        .bram_en(b_bram_en), .bram_we(b_bram_we), .bram_addr(b_bram_addr),
        .bram_wdata(b_bram_wdata), .bram_rdata(32'h0),
        .stall_cnt(b_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int ld_a;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[16] = 32'hDEADBEEF;
        bram_rdata = 32'h0;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        b_cpu_req = 1'b0; b_ldr_req = 1'b0;

        // reset state
        @(negedge clk); #1;
        chk("rst_stall", cpu_stall, 1);
        chk("rst_en", bram_en, 0);
        chk("rst_gnt", ldr_gnt, 0);
        chk("rst_cpu_rv", cpu_rvalid, 0);
        chk("rst_ldr_rv", ldr_rvalid, 0);
        chk("rst_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0;
        #1;
        chk("idle_en", bram_en, 0);
        @(negedge clk); #1;
        chk("idle_cpu_rv", cpu_rvalid, 0);
        chk("idle_ldr_rv", ldr_rvalid, 0);
        chk("idle_cnt", stall_cnt, 0);

        // CPU read of 0x010
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h010;
        #1;
        chk("rd_en", bram_en, 1);
        chk("rd_addr", bram_addr, 32'h010);
        chk("rd_we", bram_we, 0);
        chk("rd_stall", cpu_stall, 0);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("rd_rv", cpu_rvalid, 1);
        chk("rd_data", cpu_rdata, 32'hDEADBEEF);
        chk("rd_ldr_rv", ldr_rvalid, 0);
        chk("rd_en_off", bram_en, 0);
        @(negedge clk); #1;
        chk("rd_rv_pulse", cpu_rvalid, 0);

        // collision from idle
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h020; cpu_wdata = 32'h11111111;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 11'h030; ldr_wdata = 32'h22222222;
        #1;
        chk("col_gnt", ldr_gnt, 0);
        chk("col_stall", cpu_stall, 0);
        chk("col_we", bram_we, 4'hF);
        chk("col_addr", bram_addr, 32'h020);
        chk("col_wdata", bram_wdata, 32'h11111111);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("col_ldr_gnt", ldr_gnt, 1);
        chk("col_ldr_addr", bram_addr, 32'h030);
        chk("col_ldr_wdata", bram_wdata, 32'h22222222);
        @(negedge clk);
        ldr_req = 1'b0;
        #1;
        chk("col_idle", bram_en, 0);
        chk("col_mem_cpu", mem[32], 32'h11111111);
        chk("col_mem_ldr", mem[48], 32'h22222222);

        // loader burst, CPU arrives at beat 3
        ld_a = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            ldr_req = 1'b1; ldr_we = 1'b1;
            ldr_addr = 11'(ld_a); ldr_wdata = 32'hA0000000 | ld_a;
            cpu_req = (c >= 3 && c <= 9);
            cpu_we = 1'b1; cpu_addr = 11'h1FF; cpu_wdata = 32'hC0FFEE00;
            #1;
            chk($sformatf("burst_gnt_c%0d", c), ldr_gnt, (c <= 8 || c >= 10));
            chk($sformatf("burst_stall_c%0d", c), cpu_stall, (c >= 3 && c <= 8));
            if (c == 9) chk("burst_cpu_addr", bram_addr, 32'h1FF);
            if (ldr_gnt) ld_a++;
        end
        @(negedge clk);
        ldr_req = 1'b0; cpu_req = 1'b0;
        #1;
        chk("burst_cnt", stall_cnt, 6);
        chk("burst_beats", ld_a, 16);
        chk("burst_cpu_mem", mem[11'h1FF], 32'hC0FFEE00);
        for (int i = 0; i < 16; i++)
            chk($sformatf("burst_mem%0d", i), mem[i], 32'hA0000000 | i);

        // reset in the cycle after a CPU read grant
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h010;
        #1;
        chk("rstrd_en", bram_en, 1);
        @(negedge clk);
        cpu_req = 1'b0; rst = 1'b1;
        #1;
        chk("rstrd_rv", cpu_rvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstrd_rv2", cpu_rvalid, 0);
        chk("rstrd_cnt", stall_cnt, 0);

`ifdef BRAM_ARB_LDR_READ_EN
        // loader read returns data to the loader only
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 11'h010;
        #1;
        chk("lrd_gnt", ldr_gnt, 1);
        @(negedge clk);
        ldr_req = 1'b0;
        #1;
        chk("lrd_rv", ldr_rvalid, 1);
        chk("lrd_data", ldr_rdata, 32'hDEADBEEF);
        chk("lrd_cpu_rv", cpu_rvalid, 0);
        // reset during a loader read
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 11'h010;
        #1;
        chk("lrst_gnt", ldr_gnt, 1);
        @(negedge clk);
        ldr_req = 1'b0; rst = 1'b1;
        #1;
        chk("lrst_rv", ldr_rvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("lrst_rv2", ldr_rvalid, 0);
        chk("lrst_cnt", stall_cnt, 0);
`else
        // write-only loader: read requests are never granted
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 11'h010;
        #1;
        chk("lrd_gnt", ldr_gnt, 0);
        chk("lrd_en", bram_en, 0);
        @(negedge clk);
        ldr_req = 1'b0;
        #1;
        chk("lrd_rv", ldr_rvalid, 0);
        chk("lrd_data", ldr_rdata, 0);
`endif

        // owner is NONE after reset: a collision goes to the CPU
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h040;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 11'h050;
        #1;
        chk("post_rst_col", ldr_gnt, 0);
        chk("post_rst_addr", bram_addr, 32'h040);
        @(negedge clk);
        cpu_req = 1'b0; ldr_req = 1'b0;

        // saturation on instance B
        for (int p = 0; p < 260; p++) begin
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                b_ldr_req = 1'b1;
                b_cpu_req = (k != 0);
                #1;
                if (p == 1 && k == 0) chk("sat_period", b_stall_cnt, 254);
                if (p == 1 && k == 100) chk("sat_stall", b_cpu_stall, 1);
                if (p == 1 && k == 255) chk("sat_cpu_gnt", b_bram_addr, 32'h7F0);
            end
        end
        chk("sat_cnt", b_stall_cnt, 16'hFFFF);
        @(negedge clk);
        #1;
        chk("sat_hold", b_stall_cnt, 16'hFFFF);
        b_cpu_req = 1'b0; b_ldr_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
